s_matrix_buffer: RTL

Control-signal history buffer and downsampling sequencer directly upstream of the FIR hierarchical adder. It shifts in one N_MAX-bit analog-state control vector per accepted input into a K_MAX-deep history. After every downsample_rate accepted inputs it snapshots the history into a stable S_matrix and pulses start for the adder. The snapshot is held constant between starts, so the multi-cycle adder always sees a coherent window.

---
 rtl/FIR_pkg.sv | 16 +
 rtl/s_buffer_seq.sv | 133 +++++++++++++
 rtl/s_matrix_buffer.sv | 71 +++++++
 3 files changed

// File: rtl/FIR_pkg.sv
// Shared definitions for the FIR front end: control-vector type, counter width
// helper and the adder busy time that s_matrix_buffer and the adder both rely on.
package FIR_pkg;

  localparam int N_MAX_DEFAULT         = 8;
  localparam int K_MAX_DEFAULT         = 256;
  localparam int MIN_START_GAP_DEFAULT = 16;

  typedef logic [N_MAX_DEFAULT-1:0] ctrl_vec_t;

  // Wide enough to hold the value k_max itself, not just k_max-1.
  function automatic int fill_cnt_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/s_buffer_seq.sv
// Downsampling sequencer: enable edge detect, rate latch, fill/decimation/gap
// counters and start generation. Overrun logic is built only with S_BUFFER_OVERRUN_DETECT_EN.
module s_buffer_seq
  import FIR_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEFAULT,
  parameter int DSR_WIDTH     = 8,
  parameter int MIN_START_GAP = MIN_START_GAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [DSR_WIDTH-1:0] downsample_rate,
  output logic                 capture,
  output logic                 start,
  output logic                 overrun
);

  localparam int                   FILL_W    = fill_cnt_width(K_MAX);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(K_MAX);
  localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(K_MAX - 1);
  localparam logic [DSR_WIDTH-1:0] DSR_ONE   = DSR_WIDTH'(1);

  logic                 enable_q,  enable_d;
  logic [DSR_WIDTH-1:0] dsr_q,     dsr_d;
  logic [FILL_W-1:0]    fill_q,    fill_d;
  logic [DSR_WIDTH-1:0] dec_q,     dec_d;
  logic                 pend_q,    pend_d;
  logic                 start_q,   start_d;
  logic                 overrun_q, overrun_d;

`ifdef S_BUFFER_OVERRUN_DETECT_EN
  localparam int               GAP_W    = $clog2(MIN_START_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_START_GAP - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  localparam int UNUSED_MIN_START_GAP = MIN_START_GAP;
`endif

  logic                 enable_rise;
  logic [DSR_WIDTH-1:0] dsr_in;
  logic [DSR_WIDTH-1:0] dsr_eff;
  logic                 wrap;
  logic                 decim_evt;

  // The rate latched on the rising edge already governs the input accepted there.
  assign enable_rise = enable & ~enable_q;
  assign dsr_in      = (downsample_rate == '0) ? DSR_ONE : downsample_rate;
  assign dsr_eff     = enable_rise ? dsr_in : dsr_q;
  assign wrap        = enable & in_valid & (dec_q == dsr_eff - DSR_ONE);
  assign decim_evt   = wrap & (fill_q >= FILL_LAST);

  // NOTE: every *_d gets its default first, so no path through this block can infer a latch.
  always_comb begin
    enable_d  = enable;
    dsr_d     = dsr_q;
    fill_d    = fill_q;
    dec_d     = dec_q;
    pend_d    = 1'b0;
    start_d   = 1'b0;
    overrun_d = overrun_q;
`ifdef S_BUFFER_OVERRUN_DETECT_EN
    gap_d     = gap_q;
`endif
    if (!enable) begin
      fill_d = '0;
      dec_d  = '0;
`ifdef S_BUFFER_OVERRUN_DETECT_EN
      gap_d  = '0;
`endif
    end else begin
      if (enable_rise) begin
        dsr_d     = dsr_in;
        overrun_d = 1'b0;
      end
      if (in_valid) begin
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        dec_d  = wrap ? '0 : dec_q + 1'b1;
      end
      start_d = pend_q;
`ifdef S_BUFFER_OVERRUN_DETECT_EN
      if (start_d) begin
        gap_d = GAP_LOAD;
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
      // A pending start counts as busy: its gap load lands on the same edge.
      if (decim_evt) begin
        if (pend_q || (gap_q != '0)) begin
          overrun_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
      end
`else
      pend_d = decim_evt;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_q  <= 1'b0;
      dsr_q     <= DSR_ONE;
      fill_q    <= '0;
      dec_q     <= '0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef S_BUFFER_OVERRUN_DETECT_EN
      gap_q     <= '0;
`endif
    end else begin
      enable_q  <= enable_d;
      dsr_q     <= dsr_d;
      fill_q    <= fill_d;
      dec_q     <= dec_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
`ifdef S_BUFFER_OVERRUN_DETECT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  assign capture = start_d;
  assign start   = start_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/s_matrix_buffer.sv
// Control-signal history buffer feeding the FIR adder: K_MAX-deep shift history
// plus a snapshot taken on each start. Optional overrun detection: S_BUFFER_OVERRUN_DETECT_EN.
module s_matrix_buffer
  import FIR_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEFAULT,
  parameter int N_MAX         = N_MAX_DEFAULT,
  parameter int DSR_WIDTH     = 8,
  parameter int MIN_START_GAP = MIN_START_GAP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [N_MAX-1:0]     control_signal,
  input  logic [DSR_WIDTH-1:0] downsample_rate,
  output logic [N_MAX-1:0]     S_matrix [K_MAX],
  output logic                 start,
  output logic                 overrun
);

  logic [N_MAX-1:0] hist_q     [K_MAX];
  logic [N_MAX-1:0] hist_d     [K_MAX];
  logic [N_MAX-1:0] s_matrix_q [K_MAX];
  logic [N_MAX-1:0] s_matrix_d [K_MAX];
  logic             capture;

  s_buffer_seq #(
    .K_MAX         (K_MAX),
    .DSR_WIDTH     (DSR_WIDTH),
    .MIN_START_GAP (MIN_START_GAP)
  ) u_seq (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .in_valid        (in_valid),
    .downsample_rate (downsample_rate),
    .capture         (capture),
    .start           (start),
    .overrun         (overrun)
  );

  // Snapshot takes hist as it stood before this edge, so it holds the event input at index 0.
  always_comb begin
    hist_d     = hist_q;
    s_matrix_d = s_matrix_q;
    if (enable && in_valid) begin
      hist_d[0] = control_signal;
      for (int k = 1; k < K_MAX; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
    if (capture) begin
      s_matrix_d = hist_q;
    end
  end

  // NOTE: hist and the snapshot are flop arrays, not RAM, so they can and must reset to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q     <= '{default: '0};
      s_matrix_q <= '{default: '0};
    end else begin
      hist_q     <= hist_d;
      s_matrix_q <= s_matrix_d;
    end
  end

  assign S_matrix = s_matrix_q;

endmodule
